// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: EX/MEM op to data-bus transaction plus load formatting.
// Optional LSU_BUS_ERR_EN adds dbus_err, routed to lsu_misalign and a zeroed result.
module mem_lsu #(
   parameter int REG_WIDTH  = 32,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [6:0]            EX_MEM_inst_opcode,
   input  logic [2:0]            EX_MEM_funct3,
   input  logic [REG_WIDTH-1:0]  EX_MEM_alu_out,
   input  logic [REG_WIDTH-1:0]  EX_MEM_dataB,
   output logic                  dbus_req,
   output logic                  dbus_we,
   output logic [ADDR_WIDTH-1:0] dbus_addr,
   output logic [31:0]           dbus_wdata,
   output logic [3:0]            dbus_wstrb,
   input  logic                  dbus_ready,
   input  logic                  dbus_rvalid,
   input  logic [31:0]           dbus_rdata,
`ifdef LSU_BUS_ERR_EN
   input  logic                  dbus_err,
`endif
   output logic [REG_WIDTH-1:0]  DMEM_data_out,
   output logic                  lsu_stall,
   output logic                  lsu_misalign
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   state_t      state_q, state_d;
   logic        is_load, is_store, mem_op, bad, err_hit;
   logic [2:0]  f3;
   logic [2:0]  f3_q;
   logic [1:0]  lane_q;
   logic [31:0] st_wdata;
   logic [3:0]  st_wstrb;
   logic [7:0]  lbyte;
   logic [15:0] lhalf;
   logic [31:0] load_val;

   assign f3       = EX_MEM_funct3;
   assign is_load  = EX_MEM_inst_opcode == OP_LOAD;
   assign is_store = EX_MEM_inst_opcode == OP_STORE;
   assign mem_op   = is_load | is_store;

   assign bad = (is_load && (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111))
              | (is_store && f3 > 3'b010)
              | (mem_op && f3[1:0] == 2'b01 && EX_MEM_alu_out[0])
              | (mem_op && f3[1:0] == 2'b10 && EX_MEM_alu_out[1:0] != 2'b00);

`ifdef LSU_BUS_ERR_EN
   assign err_hit = dbus_err && ((state_q == REQ && dbus_ready)
                              || (state_q == WAIT && dbus_rvalid));
`else
   assign err_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (mem_op && !bad) state_d = REQ;
         REQ:     if (dbus_ready)
                     state_d = (dbus_we || err_hit) ? DONE : WAIT;
         WAIT:    if (dbus_rvalid) state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      lsu_stall    = mem_op && state_q != DONE && !bad;
      lsu_misalign = (state_q == IDLE && mem_op && bad) || err_hit;
   end

   // Store lanes are replicated so the slave only needs the strobes.
   always_comb begin
      st_wdata = EX_MEM_dataB;
      st_wstrb = 4'b1111;
      unique case (1'b1)
         (f3[1:0] == 2'b00): begin
            st_wdata = {4{EX_MEM_dataB[7:0]}};
            st_wstrb = 4'b0001 << EX_MEM_alu_out[1:0];
         end
         (f3[1:0] == 2'b01): begin
            st_wdata = {2{EX_MEM_dataB[15:0]}};
            st_wstrb = EX_MEM_alu_out[1] ? 4'b1100 : 4'b0011;
         end
         default: ;
      endcase
   end

   always_comb begin
      case (lane_q)
         2'd0:    lbyte = dbus_rdata[7:0];
         2'd1:    lbyte = dbus_rdata[15:8];
         2'd2:    lbyte = dbus_rdata[23:16];
         default: lbyte = dbus_rdata[31:24];
      endcase
      lhalf    = lane_q[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];
      load_val = dbus_rdata;
      unique case (1'b1)
         (f3_q[1:0] == 2'b00): load_val = {{24{lbyte[7] & ~f3_q[2]}}, lbyte};
         (f3_q[1:0] == 2'b01): load_val = {{16{lhalf[15] & ~f3_q[2]}}, lhalf};
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dbus_req      <= 1'b0;
         dbus_we       <= 1'b0;
         dbus_addr     <= '0;
         dbus_wdata    <= '0;
         dbus_wstrb    <= '0;
         f3_q          <= '0;
         lane_q        <= '0;
         DMEM_data_out <= '0;
      end else begin
         case (state_q)
            IDLE: if (mem_op) begin
               if (!bad) begin
                  dbus_req   <= 1'b1;
                  dbus_we    <= is_store;
                  dbus_addr  <= {EX_MEM_alu_out[ADDR_WIDTH-1:2], 2'b00};
                  dbus_wdata <= st_wdata;
                  dbus_wstrb <= is_store ? st_wstrb : 4'b0000;
                  f3_q       <= f3;
                  lane_q     <= EX_MEM_alu_out[1:0];
               end else begin
                  DMEM_data_out <= '0;
               end
            end
            REQ: if (dbus_ready) begin
               dbus_req <= 1'b0;
               if (err_hit) DMEM_data_out <= '0;
            end
            WAIT: if (dbus_rvalid)
               DMEM_data_out <= err_hit ? '0 : load_val;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu: bus responder with wait states, load/store formatting,
// misalignment pulses and reset during an access.
module tb_mem_lsu;

   localparam logic [6:0] LD = 7'b0000011;
   localparam logic [6:0] ST = 7'b0100011;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [6:0]  op;
   logic [2:0]  f3;
   logic [31:0] alu, datab;
   logic        dbus_req, dbus_we, dbus_ready, dbus_rvalid;
   logic [31:0] dbus_addr, dbus_wdata, dbus_rdata, dmem;
   logic [3:0]  dbus_wstrb;
   logic        lsu_stall, lsu_misalign;
`ifdef LSU_BUS_ERR_EN
   logic        dbus_err = 1'b0;
`endif

   int n_total = 0;
   int n_bad   = 0;
   logic [31:0] exp_q[$];
   logic [31:0] last_load = 32'h0;

   always #5 clk = ~clk;

   mem_lsu dut (
      .clk                (clk),
      .reset_n            (reset_n),
      .EX_MEM_inst_opcode (op),
      .EX_MEM_funct3      (f3),
      .EX_MEM_alu_out     (alu),
      .EX_MEM_dataB       (datab),
      .dbus_req           (dbus_req),
      .dbus_we            (dbus_we),
      .dbus_addr          (dbus_addr),
      .dbus_wdata         (dbus_wdata),
      .dbus_wstrb         (dbus_wstrb),
      .dbus_ready         (dbus_ready),
      .dbus_rvalid        (dbus_rvalid),
      .dbus_rdata         (dbus_rdata),
`ifdef LSU_BUS_ERR_EN
      .dbus_err           (dbus_err),
`endif
      .DMEM_data_out      (dmem),
      .lsu_stall          (lsu_stall),
      .lsu_misalign       (lsu_misalign)
   );

   task automatic run_op(
      input  logic [6:0]  o,
      input  logic [2:0]  fn,
      input  logic [31:0] a,
      input  logic [31:0] d,
      input  int          rw,
      input  int          vw,
      input  logic [31:0] rd,
      output int          stalls,
      output logic [31:0] f_addr,
      output logic [31:0] f_wdata,
      output logic [3:0]  f_wstrb,
      output logic        f_we,
      output logic        stable,
      output logic        tmo,
      output logic [31:0] res
   );
      int  rc, vc;
      logic acc;
      @(posedge clk); #1;
      op = o; f3 = fn; alu = a; datab = d; dbus_rdata = rd;
      dbus_ready = 1'b0; dbus_rvalid = 1'b0;
      stalls = 0; rc = 0; vc = 0; acc = 1'b0;
      stable = 1'b1; tmo = 1'b1;
      f_addr = '0; f_wdata = '0; f_wstrb = '0; f_we = 1'b0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (!lsu_stall) begin
            tmo = 1'b0;
            break;
         end
         stalls++;
         dbus_ready = 1'b0; dbus_rvalid = 1'b0;
         if (dbus_req) begin
            if (rc == 0) begin
               f_addr = dbus_addr; f_wdata = dbus_wdata;
               f_wstrb = dbus_wstrb; f_we = dbus_we;
            end else if (dbus_addr !== f_addr || dbus_wdata !== f_wdata ||
                         dbus_wstrb !== f_wstrb || dbus_we !== f_we) begin
               stable = 1'b0;
            end
            if (rc == rw) begin
               dbus_ready = 1'b1;
               acc = 1'b1;
            end
            rc++;
         end else if (acc) begin
            if (vc == vw) dbus_rvalid = 1'b1;
            vc++;
         end
      end
      dbus_ready = 1'b0; dbus_rvalid = 1'b0;
      res = dmem;
      @(posedge clk); #1;
      op = 7'h0;
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      op = 7'h0; f3 = 3'h0; alu = '0; datab = '0;
      dbus_ready = 1'b0; dbus_rvalid = 1'b0; dbus_rdata = '0;
      repeat (3) @(negedge clk);
      n_total++;
      if (dbus_req !== 1'b0 || dbus_we !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_req: req=%b we=%b need 0 0", dbus_req, dbus_we);
      end
      n_total++;
      if (dbus_addr !== 32'h0 || dbus_wdata !== 32'h0 || dbus_wstrb !== 4'h0) begin
         n_bad++;
         $display("FAIL reset_bus: addr=%h wdata=%h wstrb=%b need 0", dbus_addr, dbus_wdata, dbus_wstrb);
      end
      n_total++;
      if (dmem !== 32'h0 || lsu_stall !== 1'b0 || lsu_misalign !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_out: dmem=%h stall=%b mis=%b need 0", dmem, lsu_stall, lsu_misalign);
      end
      @(posedge clk); #1;
      reset_n = 1'b1;
   endtask

   task automatic do_store(input string nm, input logic [2:0] fn, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] e_addr,
                           input logic [31:0] e_wdata, input logic [3:0] e_wstrb);
      int st; logic [31:0] fa, fw, r; logic [3:0] fs; logic fwe, stb, tmo;
      run_op(ST, fn, a, d, 0, 0, 32'h0, st, fa, fw, fs, fwe, stb, tmo, r);
      n_total++;
      if (tmo !== 1'b0 || st != 2) begin
         n_bad++;
         $display("FAIL %s_stall: stalls=%0d tmo=%b need 2 0", nm, st, tmo);
      end
      n_total++;
      if (fa !== e_addr || fw !== e_wdata || fs !== e_wstrb || fwe !== 1'b1) begin
         n_bad++;
         $display("FAIL %s_bus: addr=%h wdata=%h wstrb=%b we=%b need %h %h %b 1",
                  nm, fa, fw, fs, fwe, e_addr, e_wdata, e_wstrb);
      end
      n_total++;
      if (r !== last_load) begin
         n_bad++;
         $display("FAIL %s_hold: dmem=%h need %h", nm, r, last_load);
      end
   endtask

   task automatic do_load(input string nm, input logic [2:0] fn, input logic [31:0] a,
                          input int rw, input int vw, input logic [31:0] rd,
                          input logic [31:0] e, input int e_st);
      int st; logic [31:0] fa, fw, r, x; logic [3:0] fs; logic fwe, stb, tmo;
      exp_q.push_back(e);
      run_op(LD, fn, a, 32'h0, rw, vw, rd, st, fa, fw, fs, fwe, stb, tmo, r);
      x = exp_q.pop_front();
      last_load = x;
      n_total++;
      if (r !== x) begin
         n_bad++;
         $display("FAIL %s_data: dmem=%h need %h", nm, r, x);
      end
      n_total++;
      if (tmo !== 1'b0 || st != e_st) begin
         n_bad++;
         $display("FAIL %s_stall: stalls=%0d tmo=%b need %0d 0", nm, st, tmo, e_st);
      end
      n_total++;
      if (fa !== {a[31:2], 2'b00} || fs !== 4'h0 || fwe !== 1'b0 || stb !== 1'b1) begin
         n_bad++;
         $display("FAIL %s_bus: addr=%h wstrb=%b we=%b stable=%b need %h 0 0 1",
                  nm, fa, fs, fwe, stb, {a[31:2], 2'b00});
      end
   endtask

   task automatic test_stores;
      do_store("sw", 3'b010, 32'h100, 32'hDEADBEEF, 32'h100, 32'hDEADBEEF, 4'b1111);
      do_store("sb", 3'b000, 32'h103, 32'h000000A5, 32'h100, 32'hA5A5A5A5, 4'b1000);
      do_store("sh", 3'b001, 32'h102, 32'h1234ABCD, 32'h100, 32'hABCDABCD, 4'b1100);
      do_store("sb1", 3'b000, 32'h201, 32'h0000005A, 32'h200, 32'h5A5A5A5A, 4'b0010);
   endtask

   task automatic test_loads;
      do_load("lb",  3'b000, 32'h102, 0, 0, 32'h0080FF00, 32'hFFFFFF80, 3);
      do_load("lbu", 3'b100, 32'h102, 0, 0, 32'h0080FF00, 32'h00000080, 3);
      do_load("lh",  3'b001, 32'h102, 0, 0, 32'h0080FF00, 32'h00000080, 3);
      do_load("lh0", 3'b001, 32'h100, 0, 0, 32'h0080FF00, 32'hFFFFFF00, 3);
      do_load("lhu", 3'b101, 32'h100, 0, 0, 32'h0080FF00, 32'h0000FF00, 3);
      do_load("lb3", 3'b000, 32'h107, 0, 0, 32'h7F000000, 32'h0000007F, 3);
   endtask

   task automatic test_lw_wait;
      do_load("lw_wait", 3'b010, 32'h300, 2, 3, 32'hCAFEF00D, 32'hCAFEF00D, 8);
   endtask

   task automatic test_back_to_back;
      do_store("b2b_sw", 3'b010, 32'h40, 32'h11223344, 32'h40, 32'h11223344, 4'b1111);
      do_load("b2b_lbu", 3'b100, 32'h41, 0, 1, 32'h11223344, 32'h00000033, 4);
   endtask

   task automatic test_misalign;
      logic [6:0]  ops[4] = '{LD, LD, LD, ST};
      logic [2:0]  fns[4] = '{3'b001, 3'b010, 3'b011, 3'b011};
      logic [31:0] ads[4] = '{32'h101, 32'h102, 32'h100, 32'h100};
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         op = ops[i]; f3 = fns[i]; alu = ads[i]; datab = 32'h55;
         @(negedge clk);
         n_total++;
         if (lsu_misalign !== 1'b1 || lsu_stall !== 1'b0 || dbus_req !== 1'b0) begin
            n_bad++;
            $display("FAIL mis%0d_pulse: mis=%b stall=%b req=%b need 1 0 0",
                     i, lsu_misalign, lsu_stall, dbus_req);
         end
         @(posedge clk); #1;
         op = 7'h0;
         @(negedge clk);
         n_total++;
         if (dmem !== 32'h0 || dbus_req !== 1'b0 || lsu_misalign !== 1'b0) begin
            n_bad++;
            $display("FAIL mis%0d_after: dmem=%h req=%b mis=%b need 0 0 0",
                     i, dmem, dbus_req, lsu_misalign);
         end
         if (i == 0) begin
            do_load("mis_reload", 3'b010, 32'h104, 0, 0, 32'h87654321, 32'h87654321, 3);
         end
      end
      last_load = 32'h0;
   endtask

   task automatic test_reset_mid;
      do_load("pre_rst", 3'b010, 32'h10, 0, 0, 32'h0BADF00D, 32'h0BADF00D, 3);
      @(posedge clk); #1;
      op = LD; f3 = 3'b010; alu = 32'h200; dbus_rdata = 32'h12345678;
      @(negedge clk);
      @(negedge clk);
      n_total++;
      if (dbus_req !== 1'b1) begin
         n_bad++;
         $display("FAIL rst_mid_req: req=%b need 1", dbus_req);
      end
      dbus_ready = 1'b1;
      @(negedge clk);
      dbus_ready = 1'b0;
      reset_n = 1'b0;
      #1;
      n_total++;
      if (dbus_req !== 1'b0 || dmem !== 32'h0) begin
         n_bad++;
         $display("FAIL rst_mid_drop: req=%b dmem=%h need 0 0", dbus_req, dmem);
      end
      @(posedge clk); #1;
      op = 7'h0;
      reset_n = 1'b1;
      dbus_rvalid = 1'b1;
      @(negedge clk);
      n_total++;
      if (dbus_req !== 1'b0 || lsu_stall !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_mid_idle: req=%b stall=%b need 0 0", dbus_req, lsu_stall);
      end
      @(posedge clk); #1;
      dbus_rvalid = 1'b0;
      @(negedge clk);
      n_total++;
      if (dmem !== 32'h0 || dbus_req !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_mid_late_rvalid: dmem=%h req=%b need 0 0", dmem, dbus_req);
      end
      last_load = 32'h0;
      do_load("post_rst", 3'b001, 32'h22, 0, 0, 32'h8001FFFF, 32'hFFFF8001, 3);
   endtask

   initial begin
      test_reset();
      test_stores();
      test_loads();
      test_lw_wait();
      test_back_to_back();
      test_misalign();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Load/store unit for the MEM stage of the 5-stage RV32I pipeline.
- Sits between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Converts EX/MEM load/store ops into a data-bus transaction with byte strobes, formats load data (sign/zero extension), and stalls the pipeline while the access is in flight.
- Its registered DMEM_data_out feeds the DMEM_data_out input of the MEM/WB register.

Parameters:
REG_WIDTH, 32, data width; only 32 supported.
ADDR_WIDTH, 32, data-bus address width.

Ports:
clk  input  1  clock.
reset_n  input  1  asynchronous, active-low reset.
EX_MEM_inst_opcode  input  7  opcode; load = 7'b0000011, store = 7'b0100011.
EX_MEM_funct3  input  3  access size and sign.
EX_MEM_alu_out  input  REG_WIDTH  effective address.
EX_MEM_dataB  input  REG_WIDTH  store data.
dbus_req  output  1  request valid (registered).
dbus_we  output  1  1 = store.
dbus_addr  output  ADDR_WIDTH  word-aligned address; bits [1:0] = 0.
dbus_wdata  output  32  lane-replicated store data.
dbus_wstrb  output  4  byte strobes; 0 for loads.
dbus_ready  input  1  request accepted when dbus_req && dbus_ready.
dbus_rvalid  input  1  load response valid.
dbus_rdata  input  32  load response word.
DMEM_data_out  output  REG_WIDTH  formatted load result (registered).
lsu_stall  output  1  hold IF/ID/EX/EX_MEM stages.
lsu_misalign  output  1  one-cycle pulse on misaligned or illegal access.

Behaviour:
- Reset values: all outputs 0; state = IDLE.
- mem_op = opcode is load or store.
- lsu_stall = mem_op && state != DONE && !bad. It is combinational, so it is asserted in the same cycle the op appears.

bad (misaligned or illegal access):
- Halfword with addr[0] = 1.
- Word with addr[1:0] != 0.
- Load funct3 in {011, 110, 111}.
- Store funct3 > 010.

FSM:
- IDLE:
  - If mem_op && !bad: register addr/data/strb, set dbus_req = 1, go to REQ.
  - If mem_op && bad: lsu_misalign = 1 for this cycle, no bus access, no stall, stay in IDLE, DMEM_data_out <= 0.
- REQ:
  - Hold dbus_req and all bus fields stable until dbus_ready.
  - On dbus_ready: dbus_req <= 0; store goes to DONE, load goes to WAIT.
- WAIT:
  - dbus_rvalid is sampled only in this state, so the response arrives at the earliest one cycle after acceptance.
  - On dbus_rvalid: DMEM_data_out <= formatted data; go to DONE.
- DONE:
  - Stall deasserted for exactly one cycle; MEM/WB captures DMEM_data_out.
  - Go to IDLE. The next op is seen in IDLE on the following cycle.

Store formatting:
- SB: wdata = {4{byte}}, wstrb = 4'b0001 << addr[1:0].
- SH: wdata = {2{half}}, wstrb = addr[1] ? 4'b1100 : 4'b0011.
- SW: wstrb = 4'b1111.

Load formatting (lane selected by the captured addr[1:0]):
- LB/LH: sign-extend.
- LBU/LHU: zero-extend.
- LW: full word.

Other rules:
- DMEM_data_out holds its value across non-load ops and stores.
- Latency with zero-wait bus: store stalls 2 cycles; load stalls 3 cycles.
- Bus wait states extend REQ or WAIT one cycle per wait cycle, with no upper bound.
- Reset mid-access: return to IDLE and drop dbus_req immediately. A late dbus_rvalid arriving in IDLE is ignored.
- dbus_rvalid outside WAIT is ignored.

Optional Feature:
- LSU_BUS_ERR_EN.
- Defined:
  - Adds input dbus_err (1 bit), sampled with dbus_ready in REQ and with dbus_rvalid in WAIT.
  - When set: go to DONE, DMEM_data_out <= 0, pulse lsu_misalign for one cycle (shared fault output).
- Undefined: no dbus_err port and no error path.

Test Plan:
- SW addr 0x100, data 0xDEADBEEF, ready on first REQ cycle -> dbus_addr 0x100, wstrb 1111, stall high for 2 cycles, DONE on cycle 3.
- SB addr 0x103, dataB 0x000000A5 -> wdata 0xA5A5A5A5, wstrb 1000.
- LB addr 0x102, rdata 0x0080FF00 -> DMEM_data_out 0xFFFFFF80. LBU at the same address -> 0x00000080. LH addr 0x102 -> 0x00000080.
- LW with 2 ready-wait cycles and 3 rvalid-wait cycles -> stall high for 8 cycles; bus fields stable throughout REQ; result = rdata.
- LH addr 0x101 -> lsu_misalign pulse, dbus_req stays 0, stall 0, DMEM_data_out 0.
- reset_n low during WAIT, then rvalid in IDLE -> state IDLE, dbus_req 0, DMEM_data_out stays 0.
